// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO for any DEPTH >= 2 with level, almost-full/empty flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output instead of the registered read.
module fifo_sync_flags #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_write,
   input  logic [WIDTH-1:0]             fifo_data_in,
   input  logic                         fifo_read,
   output logic [WIDTH-1:0]             fifo_data_out,
   output logic                         fifo_data_valid,
   output logic                         fifo_full,
   output logic                         fifo_empty,
   output logic                         fifo_almost_full,
   output logic                         fifo_almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic                         fifo_overflow,
   output logic                         fifo_underflow,
   input  logic                         err_clear
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             rd_ok;
   logic             wr_ok;

   assign fifo_full         = (fifo_level == LW'(DEPTH));
   assign fifo_empty        = (fifo_level == '0);
   assign fifo_almost_full  = (fifo_level >= LW'(AF_THRESH));
   assign fifo_almost_empty = (fifo_level <= LW'(AE_THRESH));

   // A read accepted while full frees a slot, so a same-cycle write is accepted too.
   assign rd_ok = fifo_read && !fifo_empty;
   assign wr_ok = fifo_write && (!fifo_full || rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= fifo_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // A set event in the same cycle takes priority over err_clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_overflow  <= 1'b0;
         fifo_underflow <= 1'b0;
      end else begin
         if (fifo_write && !wr_ok) begin
            fifo_overflow <= 1'b1;
         end else if (err_clear) begin
            fifo_overflow <= 1'b0;
         end
         if (fifo_read && !rd_ok) begin
            fifo_underflow <= 1'b1;
         end else if (err_clear) begin
            fifo_underflow <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   // Output forced to zero while empty so reset shows a clean bus despite unreset storage.
   assign fifo_data_out   = fifo_empty ? '0 : mem[rd_ptr];
   assign fifo_data_valid = !fifo_empty;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_data_out   <= '0;
         fifo_data_valid <= 1'b0;
      end else begin
         fifo_data_valid <= rd_ok;
         if (rd_ok) begin
            fifo_data_out <= mem[rd_ptr];
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: a DEPTH=16 and a DEPTH=5 FIFO checked against queue-based models.
module tb_fifo_sync_flags;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_wr, a_rd, a_clr;
   logic [15:0] a_din, a_dout;
   logic        a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [4:0]  a_level;

   logic        b_wr, b_rd, b_clr;
   logic [15:0] b_din, b_dout;
   logic        b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0]  b_level;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] m_out[2];
   logic        m_valid[2];
   logic        m_ovf[2];
   logic        m_unf[2];

   always #5 clk = ~clk;

   fifo_sync_flags #(.WIDTH(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut_a (
      .clk(clk), .rst(rst),
      .fifo_write(a_wr), .fifo_data_in(a_din), .fifo_read(a_rd),
      .fifo_data_out(a_dout), .fifo_data_valid(a_valid),
      .fifo_full(a_full), .fifo_empty(a_empty),
      .fifo_almost_full(a_af), .fifo_almost_empty(a_ae),
      .fifo_level(a_level), .fifo_overflow(a_ovf), .fifo_underflow(a_unf),
      .err_clear(a_clr)
   );

   fifo_sync_flags #(.WIDTH(16), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut_b (
      .clk(clk), .rst(rst),
      .fifo_write(b_wr), .fifo_data_in(b_din), .fifo_read(b_rd),
      .fifo_data_out(b_dout), .fifo_data_valid(b_valid),
      .fifo_full(b_full), .fifo_empty(b_empty),
      .fifo_almost_full(b_af), .fifo_almost_empty(b_ae),
      .fifo_level(b_level), .fifo_overflow(b_ovf), .fifo_underflow(b_unf),
      .err_clear(b_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_out[i]   = '0;
         m_valid[i] = 1'b0;
         m_ovf[i]   = 1'b0;
         m_unf[i]   = 1'b0;
      end
   endtask

   task automatic check_all(input int which);
      int          size, dep, af, ae;
      logic [15:0] head;
      logic [15:0] e_out;
      logic        e_valid;
      string       p;
      p    = (which == 0) ? "A" : "B";
      size = (which == 0) ? q0.size() : q1.size();
      head = '0;
      if (size != 0) head = (which == 0) ? q0[0] : q1[0];
      dep  = (which == 0) ? 16 : 5;
      af   = (which == 0) ? 14 : 4;
      ae   = (which == 0) ? 2 : 1;
`ifdef FIFO_FWFT_EN
      e_out   = head;
      e_valid = (size != 0);
`else
      e_out   = m_out[which];
      e_valid = m_valid[which];
`endif
      if (which == 0) begin
         check({p, ".level"}, 32'(a_level), 32'(size));
         check({p, ".full"},  32'(a_full),  32'(size == dep));
         check({p, ".empty"}, 32'(a_empty), 32'(size == 0));
         check({p, ".afull"}, 32'(a_af),    32'(size >= af));
         check({p, ".aempty"},32'(a_ae),    32'(size <= ae));
         check({p, ".ovf"},   32'(a_ovf),   32'(m_ovf[0]));
         check({p, ".unf"},   32'(a_unf),   32'(m_unf[0]));
         check({p, ".valid"}, 32'(a_valid), 32'(e_valid));
         check({p, ".dout"},  32'(a_dout),  32'(e_out));
      end else begin
         check({p, ".level"}, 32'(b_level), 32'(size));
         check({p, ".full"},  32'(b_full),  32'(size == dep));
         check({p, ".empty"}, 32'(b_empty), 32'(size == 0));
         check({p, ".afull"}, 32'(b_af),    32'(size >= af));
         check({p, ".aempty"},32'(b_ae),    32'(size <= ae));
         check({p, ".ovf"},   32'(b_ovf),   32'(m_ovf[1]));
         check({p, ".unf"},   32'(b_unf),   32'(m_unf[1]));
         check({p, ".valid"}, 32'(b_valid), 32'(e_valid));
         check({p, ".dout"},  32'(b_dout),  32'(e_out));
      end
   endtask

   // One clock cycle on one instance: drive, clock, update the model, then compare.
   task automatic step(input int which, input logic w, input logic [15:0] d,
                       input logic r, input logic clr);
      logic [15:0] q[$];
      int          dep;
      bit          rd_ok, wr_ok;
      if (which == 0) begin
         a_wr = w; a_din = d; a_rd = r; a_clr = clr;
      end else begin
         b_wr = w; b_din = d; b_rd = r; b_clr = clr;
      end
      @(posedge clk);
      if (which == 0) q = q0; else q = q1;
      dep   = (which == 0) ? 16 : 5;
      rd_ok = r && (q.size() != 0);
      wr_ok = w && ((q.size() < dep) || rd_ok);
      m_valid[which] = rd_ok;
      if (rd_ok) m_out[which] = q.pop_front();
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ovf[which] = 1'b1;
      else if (clr)    m_ovf[which] = 1'b0;
      if (r && !rd_ok) m_unf[which] = 1'b1;
      else if (clr)    m_unf[which] = 1'b0;
      if (which == 0) q0 = q; else q1 = q;
      #1;
      a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0;
      b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0;
      check_all(which);
   endtask

   initial begin
      int wr_cnt, rd_cnt, sz;
      logic w, r;
      rst = 1'b1;
      a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = '0;
      b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all(0);
      check_all(1);
      rst = 1'b0;

      // Async reset mid-transfer at level 5 with an error flag and data_out non-zero
      step(0, 1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(0, 1'b1, 16'($urandom) | 16'h1, 1'b0, 1'b0);
      step(0, 1'b0, 16'h0, 1'b1, 1'b0);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check_all(0);
      check_all(1);
      #1 rst = 1'b0;

      // Fill 1..16, overflow on the 17th, drain in order
      for (int i = 1; i <= 16; i++) step(0, 1'b1, 16'(i), 1'b0, 1'b0);
      step(0, 1'b1, 16'd17, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(0, 1'b0, 16'h0, 1'b0, 1'b1);

      // Full with simultaneous write and read
      for (int i = 0; i < 16; i++) step(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      step(0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(0, 1'b0, 16'h0, 1'b1, 1'b0);

      // Empty with simultaneous write and read
      step(0, 1'b1, 16'hA5A5, 1'b1, 1'b0);
      step(0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(0, 1'b0, 16'h0, 1'b0, 1'b1);

      // Single word into empty, observe without a read, then pop
      step(0, 1'b1, 16'h1234, 1'b0, 1'b0);
      step(0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(0, 1'b0, 16'h0, 1'b1, 1'b0);

      // DEPTH=5 instance: stream 40 words with random overlap
      wr_cnt = 0;
      rd_cnt = 0;
      for (int c = 0; c < 2000 && rd_cnt < 40; c++) begin
         w  = (wr_cnt < 40) && ($urandom_range(3) != 0);
         r  = ($urandom_range(2) != 0);
         sz = q1.size();
         if (r && sz != 0) rd_cnt++;
         if (w && (sz < 5 || (r && sz != 0))) wr_cnt++;
         step(1, w, 16'($urandom), r, $urandom_range(7) == 0);
      end
      check("B.stream_done", 32'(rd_cnt), 32'd40);

      // DEPTH=16 instance: random traffic including errors and clears
      for (int c = 0; c < 300; c++) begin
         step(0, $urandom_range(9) < 6, 16'($urandom), $urandom_range(9) < 4,
              $urandom_range(15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
